nr_recip_vec_unit: RTL and testbench

- Parametrised successor to the ray-direction inverse block. Computes per-channel fixed-point reciprocals 1/d for CHANNELS lanes in lockstep, using an iterative non-restoring core with one quotient bit per cycle.
- Adds a valid/ready handshake, backpressure, skip early-out, a pass-through tag, and explicit zero/overflow saturation with per-lane flags.
- Sits between ray generation and the slab/AABB test stage.

---
 rtl/nr_recip_vec_unit_pkg.sv | 17 +
 rtl/nr_recip_lane.sv | 105 ++++++++++
 rtl/nr_recip_vec_unit.sv | 130 +++++++++++++
 tb/tb_nr_recip_vec_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nr_recip_vec_unit_pkg.sv
// Shared constants and FSM state type for the vector reciprocal unit.
// Defaults describe a Q3.12 datapath with three lanes.
package nr_recip_vec_unit_pkg;

  localparam int WIDTH = 16;
  localparam int Q_BITS = 12;
  localparam logic [WIDTH-1:0] MAX_16 = 16'h7FFF;
  localparam logic [WIDTH-1:0] MIN_16 = 16'h8000;
  localparam logic [WIDTH-1:0] ONE_FIXED = 16'(1 << Q_BITS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } recip_state_t;

endpackage

// File: rtl/nr_recip_lane.sv
// One reciprocal lane: non-restoring divider of a shifted 1.0 by |d|,
// plus remainder correction, sign restore and saturation.
module nr_recip_lane
  import nr_recip_vec_unit_pkg::*;
#(
  parameter int WIDTH = nr_recip_vec_unit_pkg::WIDTH,
  parameter int Q_BITS = nr_recip_vec_unit_pkg::Q_BITS,
  parameter logic [WIDTH-1:0] MAX = nr_recip_vec_unit_pkg::MAX_16,
  parameter logic [WIDTH-1:0] MIN = nr_recip_vec_unit_pkg::MIN_16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             div_bit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] recip,
  output logic             sat
);

  localparam int QW = WIDTH + Q_BITS;
  // Remainder stays within (-2|d|-1, 2|d|+1) and |d| needs WIDTH+1 bits.
  localparam int RW = WIDTH + 3;

  logic [WIDTH:0]         mag_reg;
  logic                   neg_reg;
  logic                   zero_reg;
  logic signed [RW-1:0]   rem_reg;
  logic [QW-1:0]          quo_reg;
  logic [WIDTH-1:0]       recip_reg;
  logic                   sat_reg;

  logic [WIDTH:0]         d_ext;
  logic [WIDTH:0]         mag_next;
  logic signed [RW-1:0]   divisor;
  logic signed [RW-1:0]   rem_shift;
  logic signed [RW-1:0]   rem_next;
  logic signed [RW-1:0]   rem_fix;
  logic [QW-1:0]          quo_next;
  logic [WIDTH-1:0]       q_trunc;
  logic [WIDTH-1:0]       recip_next;
  logic                   sat_next;

  always_comb begin
    d_ext     = {d[WIDTH-1], d};
    mag_next  = d[WIDTH-1] ? -d_ext : d_ext;
    divisor   = {{(RW-WIDTH-1){1'b0}}, mag_reg};
    rem_shift = {rem_reg[RW-2:0], div_bit};
    rem_next  = rem_reg[RW-1] ? rem_shift + divisor : rem_shift - divisor;
    // A non-negative partial remainder yields a 1 quotient bit; the bits
    // already form floor(dividend/|d|), only the remainder needs fixing.
    quo_next  = (quo_reg << 1) | {{(QW-1){1'b0}}, ~rem_next[RW-1]};
    rem_fix   = rem_next[RW-1] ? rem_next + divisor : rem_next;
    q_trunc   = quo_next[WIDTH-1:0];

    recip_next = MAX;
    sat_next   = 1'b1;
    if (zero_reg) begin
      recip_next = MAX;
    end else if (quo_next > QW'(MAX)) begin
      recip_next = neg_reg ? MIN : MAX;
    end else begin
      sat_next   = 1'b0;
      recip_next = neg_reg ? -q_trunc : q_trunc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_reg   <= '0;
      neg_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      recip_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      if (clear) begin
        recip_reg <= '0;
        sat_reg   <= 1'b0;
      end
      if (load) begin
        mag_reg  <= mag_next;
        neg_reg  <= d[WIDTH-1];
        zero_reg <= (d == '0);
        rem_reg  <= '0;
        quo_reg  <= '0;
      end
      if (step) begin
        rem_reg <= finish ? rem_fix : rem_next;
        quo_reg <= quo_next;
      end
      if (finish) begin
        recip_reg <= recip_next;
        sat_reg   <= sat_next;
      end
    end
  end

  assign recip = recip_reg;
  assign sat   = sat_reg;

endmodule

// File: rtl/nr_recip_vec_unit.sv
// Lockstep fixed-point reciprocal of CHANNELS divisors with a valid/ready
// handshake, skip early-out and pass-through tag.
module nr_recip_vec_unit
  import nr_recip_vec_unit_pkg::*;
#(
  parameter int WIDTH = nr_recip_vec_unit_pkg::WIDTH,
  parameter int Q_BITS = nr_recip_vec_unit_pkg::Q_BITS,
  parameter int CHANNELS = 3,
  parameter logic [WIDTH-1:0] MAX = nr_recip_vec_unit_pkg::MAX_16,
  parameter logic [WIDTH-1:0] MIN = nr_recip_vec_unit_pkg::MIN_16,
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_skip,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [CHANNELS*WIDTH-1:0] in_dir,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_recip,
  output logic [CHANNELS-1:0]       out_sat,
  output logic                      out_skip,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy
);

  localparam int ITER = WIDTH + Q_BITS;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [ITER-1:0] ONE_Q = ITER'(1) << Q_BITS;
  localparam logic [ITER-1:0] DIVIDEND = ONE_Q << Q_BITS;

  recip_state_t     state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [ITER-1:0]  div_sr_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             skip_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic accept;
  logic load;
  logic step;
  logic finish;

  assign accept = (state_reg == IDLE) && in_valid;
  assign load   = accept && !in_skip;
  assign step   = (state_reg == BUSY);
  // The last step and the result write share a cycle so the result lands
  // ITER+1 cycles after acceptance.
  assign finish = step && (cnt_reg == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      div_sr_reg    <= '0;
      tag_reg       <= '0;
      skip_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            tag_reg      <= in_tag;
            skip_reg     <= in_skip;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (in_skip) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg  <= BUSY;
              cnt_reg    <= CW'(ITER);
              div_sr_reg <= DIVIDEND;
            end
          end
        end
        BUSY: begin
          cnt_reg    <= cnt_reg - CW'(1);
          div_sr_reg <= div_sr_reg << 1;
          if (cnt_reg == CW'(1)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    nr_recip_lane #(
      .WIDTH (WIDTH),
      .Q_BITS(Q_BITS),
      .MAX   (MAX),
      .MIN   (MIN)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .load   (load),
      .step   (step),
      .finish (finish),
      .div_bit(div_sr_reg[ITER-1]),
      .d      (in_dir[gi*WIDTH +: WIDTH]),
      .recip  (out_recip[gi*WIDTH +: WIDTH]),
      .sat    (out_sat[gi])
    );
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_skip  = skip_reg;
  assign out_tag   = tag_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_nr_recip_vec_unit.sv
// Directed table-driven bench for nr_recip_vec_unit with hand-computed
// reciprocals, plus backpressure and mid-operation reset sequences.
module tb_nr_recip_vec_unit;

  localparam int W  = 16;
  localparam int CH = 3;
  localparam int TW = 4;
  localparam int MAX_WAIT = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_skip;
  logic [TW-1:0]    in_tag;
  logic [CH*W-1:0]  in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [CH*W-1:0]  out_recip;
  logic [CH-1:0]    out_sat;
  logic             out_skip;
  logic [TW-1:0]    out_tag;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [CH*W-1:0] dir;
    logic            skip;
    logic [TW-1:0]   tag;
    logic [CH*W-1:0] exp_recip;
    logic [CH-1:0]   exp_sat;
    int              exp_lat;
  } vec_t;

  vec_t vecs[7];

  nr_recip_vec_unit dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_skip  (in_skip),
    .in_tag   (in_tag),
    .in_dir   (in_dir),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_recip(out_recip),
    .out_sat  (out_sat),
    .out_skip (out_skip),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accepting edge, then drop in_valid.
  task automatic issue(input logic [CH*W-1:0] dir, input logic skip, input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_dir   = dir;
    in_skip  = skip;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
  endtask

  // Called one edge after acceptance; returns edges since acceptance.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    issue(v.dir, v.skip, v.tag);
    wait_valid(lat);
    $display("txn %0d tag=%h skip=%0b dir=%h recip=%h sat=%b lat=%0d",
             idx, v.tag, v.skip, v.dir, out_recip, out_sat, lat);
    check($sformatf("latency[%0d]", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("recip[%0d]", idx), 64'(out_recip), 64'(v.exp_recip));
    check($sformatf("sat[%0d]", idx), 64'(out_sat), 64'(v.exp_sat));
    check($sformatf("tag[%0d]", idx), 64'(out_tag), 64'(v.tag));
    check($sformatf("skip[%0d]", idx), 64'(out_skip), 64'(v.skip));
    check($sformatf("busy_done[%0d]", idx), 64'(busy), 64'd1);
    check($sformatf("in_ready_done[%0d]", idx), 64'(in_ready), 64'd0);
    handshake();
    check($sformatf("valid_after_hs[%0d]", idx), 64'(out_valid), 64'd0);
    check($sformatf("busy_after_hs[%0d]", idx), 64'(busy), 64'd0);
    check($sformatf("ready_after_hs[%0d]", idx), 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic pulse_seen;
    vec_t v;

    // {lane2, lane1, lane0}; 2^24 / |d| truncated, saturated above 0x7FFF.
    vecs[0] = '{48'h1000_2000_F000, 1'b0, 4'h5, 48'h1000_0800_F000, 3'b000, 29};
    vecs[1] = '{48'h0000_0001_FFFF, 1'b0, 4'h3, 48'h7FFF_7FFF_8000, 3'b111, 29};
    vecs[2] = '{48'h1234_5678_9ABC, 1'b1, 4'h9, 48'h0000_0000_0000, 3'b000, 1};
    vecs[3] = '{48'h8000_0800_E000, 1'b0, 4'hA, 48'hFE00_2000_F800, 3'b000, 29};
    vecs[4] = '{48'h0003_0200_0201, 1'b0, 4'h1, 48'h7FFF_7FFF_7FC0, 3'b110, 29};
    vecs[5] = '{48'h3000_FDFF_FE00, 1'b0, 4'hC, 48'h0555_8040_8000, 3'b001, 29};
    vecs[6] = '{48'hFFF0_0C00_7FFF, 1'b0, 4'h6, 48'h8000_1555_0200, 3'b100, 29};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_skip   = 1'b0;
    in_tag    = '0;
    in_dir    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_recip", 64'(out_recip), 64'd0);
    check("reset_sat", 64'(out_sat), 64'd0);
    check("reset_skip", 64'(out_skip), 64'd0);
    check("reset_tag", 64'(out_tag), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: DONE holds while a competing request waits.
    issue(vecs[0].dir, 1'b0, vecs[0].tag);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd29);
    in_valid = 1'b1;
    in_dir   = 48'h0800_0800_0800;
    in_skip  = 1'b0;
    in_tag   = 4'h7;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_recip_hold[%0d]", i), 64'(out_recip), 64'(vecs[0].exp_recip));
      check($sformatf("bp_valid_hold[%0d]", i), 64'(out_valid), 64'd1);
      check($sformatf("bp_in_ready[%0d]", i), 64'(in_ready), 64'd0);
      check($sformatf("bp_tag_hold[%0d]", i), 64'(out_tag), 64'(vecs[0].tag));
    end
    $display("txn bp tag=%h recip=%h held 10 cycles", out_tag, out_recip);
    handshake();
    check("bp_valid_after_hs", 64'(out_valid), 64'd0);
    check("bp_ready_after_hs", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second_accepted", 64'(busy), 64'd1);
    wait_valid(lat);
    $display("txn bp2 tag=%h recip=%h sat=%b lat=%0d", out_tag, out_recip, out_sat, lat);
    check("bp2_latency", 64'(lat), 64'd29);
    check("bp2_recip", 64'(out_recip), 64'h2000_2000_2000);
    check("bp2_tag", 64'(out_tag), 64'h7);
    handshake();

    // Reset in the middle of BUSY aborts without an output pulse.
    issue(vecs[0].dir, 1'b0, 4'hE);
    repeat (9) tick();
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_tag", 64'(out_tag), 64'd0);
    check("abort_recip", 64'(out_recip), 64'd0);
    pulse_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) pulse_seen = 1'b1;
    end
    check("abort_no_pulse", 64'(pulse_seen), 64'd0);
    $display("txn abort tag=E reset mid-busy, pulse_seen=%0b", pulse_seen);
    v = '{48'h0800_0800_0800, 1'b0, 4'h2, 48'h2000_2000_2000, 3'b000, 29};
    run_vec(7, v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
